// File: rtl/ddr3_mig_bridge.sv
// Bridges 256-bit cache line requests onto the MIG DDR3 native app interface
// as two 128-bit BL8 beats (low half first), with registered handshake outputs.
module ddr3_mig_bridge #(
  parameter int unsigned APP_ADDR_WIDTH = 28,
  parameter int unsigned APP_DATA_WIDTH = 128
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   addr_i,
  input  logic [2*APP_DATA_WIDTH-1:0]   data_i,
  output logic [2*APP_DATA_WIDTH-1:0]   data_o,
  input  logic                          we_i,
  input  logic                          rd_i,
  output logic                          ack_o,
  input  logic                          calib_done_i,
  output logic [APP_ADDR_WIDTH-1:0]     app_addr_o,
  output logic [2:0]                    app_cmd_o,
  output logic                          app_en_o,
  input  logic                          app_rdy_i,
  output logic [APP_DATA_WIDTH-1:0]     app_wdf_data_o,
  output logic                          app_wdf_wren_o,
  output logic                          app_wdf_end_o,
  output logic [APP_DATA_WIDTH/8-1:0]   app_wdf_mask_o,
  input  logic                          app_wdf_rdy_i,
  input  logic [APP_DATA_WIDTH-1:0]     app_rd_data_i,
  input  logic                          app_rd_data_valid_i,
  input  logic                          app_rd_data_end_i
);

  localparam int unsigned DW = APP_DATA_WIDTH;
  localparam int unsigned LW = 2 * APP_DATA_WIDTH;
  localparam int unsigned HW = APP_ADDR_WIDTH - 4;
  localparam logic [2:0]  CMD_WR = 3'b000;
  localparam logic [2:0]  CMD_RD = 3'b001;

  typedef enum logic [3:0] {
    IDLE, WD0, WC0, WD1, WC1, RC0, RC1, RWAIT, ACK, HOLD
  } state_t;

  state_t         state;
  logic [LW-1:0]  line;      // write line, or read staging while beats arrive
  logic [HW-1:0]  base_hi;   // burst base address above the 8-word BL8 boundary
  logic [1:0]     rd_beats;
  logic           cmd_done;
  logic           beat_done;
  logic           rd_beat;
  logic           unused_bits;

  assign cmd_done       = app_en_o & app_rdy_i;
  assign beat_done      = app_wdf_wren_o & app_wdf_rdy_i;
  assign rd_beat        = app_rd_data_valid_i && (state == RC1 || state == RWAIT)
                          && (rd_beats != 2'd2);
  assign app_wdf_end_o  = app_wdf_wren_o;
  assign app_wdf_mask_o = '0;
  assign unused_bits    = ^{app_rd_data_end_i, addr_i[4:0], addr_i[31:APP_ADDR_WIDTH+1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      line           <= '0;
      base_hi        <= '0;
      rd_beats       <= 2'd0;
      data_o         <= '0;
      ack_o          <= 1'b0;
      app_addr_o     <= '0;
      app_cmd_o      <= 3'b000;
      app_en_o       <= 1'b0;
      app_wdf_data_o <= '0;
      app_wdf_wren_o <= 1'b0;
    end else begin
      ack_o <= 1'b0;

      // In-order read beats land in the staging line; RC1 catches early returns
      if (rd_beat) begin
        if (rd_beats == 2'd0) line[DW-1:0]  <= app_rd_data_i;
        else                  line[LW-1:DW] <= app_rd_data_i;
        rd_beats <= rd_beats + 2'd1;
      end

      case (state)
        IDLE: begin
          if (calib_done_i && (we_i || rd_i)) begin
            base_hi  <= addr_i[APP_ADDR_WIDTH:5];
            rd_beats <= 2'd0;
            if (we_i) begin
              line           <= data_i;
              app_wdf_data_o <= data_i[DW-1:0];
              app_wdf_wren_o <= 1'b1;
              state          <= WD0;
            end else begin
              app_cmd_o  <= CMD_RD;
              app_addr_o <= {addr_i[APP_ADDR_WIDTH:5], 4'h0};
              app_en_o   <= 1'b1;
              state      <= RC0;
            end
          end
        end
        WD0: begin
          if (beat_done) begin
            app_wdf_wren_o <= 1'b0;
            app_cmd_o      <= CMD_WR;
            app_addr_o     <= {base_hi, 4'h0};
            app_en_o       <= 1'b1;
            state          <= WC0;
          end
        end
        WC0: begin
          if (cmd_done) begin
            app_en_o       <= 1'b0;
            app_wdf_data_o <= line[LW-1:DW];
            app_wdf_wren_o <= 1'b1;
            state          <= WD1;
          end
        end
        WD1: begin
          if (beat_done) begin
            app_wdf_wren_o <= 1'b0;
            app_cmd_o      <= CMD_WR;
            app_addr_o     <= {base_hi, 4'h8};
            app_en_o       <= 1'b1;
            state          <= WC1;
          end
        end
        WC1: begin
          if (cmd_done) begin
            app_en_o <= 1'b0;
            ack_o    <= 1'b1;
            state    <= ACK;
          end
        end
        RC0: begin
          if (cmd_done) begin
            app_addr_o <= {base_hi, 4'h8};
            state      <= RC1;
          end
        end
        RC1: begin
          if (cmd_done) begin
            app_en_o <= 1'b0;
            state    <= RWAIT;
          end
        end
        RWAIT: begin
          // data_o only changes here so it holds from ack until the next read ends
          if (rd_beats == 2'd2) begin
            data_o <= line;
            ack_o  <= 1'b1;
            state  <= ACK;
          end else if (rd_beat && rd_beats == 2'd1) begin
            data_o <= {app_rd_data_i, line[DW-1:0]};
            ack_o  <= 1'b1;
            state  <= ACK;
          end
        end
        ACK:     state <= HOLD;
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_mig_bridge.sv
// Directed bench for ddr3_mig_bridge: a table of line transactions run against
// a scripted MIG, plus hand-written reset-abort and stray-beat sequences.
module tb_ddr3_mig_bridge;

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 128;
  localparam int unsigned LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   addr_i;
  logic [LW-1:0] data_i;
  logic [LW-1:0] data_o;
  logic          we_i, rd_i, ack_o, calib_done_i;
  logic [AW-1:0] app_addr_o;
  logic [2:0]    app_cmd_o;
  logic          app_en_o, app_rdy_i;
  logic [DW-1:0] app_wdf_data_o;
  logic          app_wdf_wren_o, app_wdf_end_o;
  logic [15:0]   app_wdf_mask_o;
  logic          app_wdf_rdy_i;
  logic [DW-1:0] app_rd_data_i;
  logic          app_rd_data_valid_i, app_rd_data_end_i;

  always #5 clk = ~clk;

  ddr3_mig_bridge #(.APP_ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
    .we_i(we_i), .rd_i(rd_i), .ack_o(ack_o), .calib_done_i(calib_done_i),
    .app_addr_o(app_addr_o), .app_cmd_o(app_cmd_o), .app_en_o(app_en_o),
    .app_rdy_i(app_rdy_i), .app_wdf_data_o(app_wdf_data_o),
    .app_wdf_wren_o(app_wdf_wren_o), .app_wdf_end_o(app_wdf_end_o),
    .app_wdf_mask_o(app_wdf_mask_o), .app_wdf_rdy_i(app_wdf_rdy_i),
    .app_rd_data_i(app_rd_data_i), .app_rd_data_valid_i(app_rd_data_valid_i),
    .app_rd_data_end_i(app_rd_data_end_i)
  );

  typedef struct packed {
    logic [2:0]    cmd;
    logic [AW-1:0] addr;
  } cmd_t;

  typedef struct {
    logic          we;
    logic          rd;
    logic [31:0]   addr;
    logic [LW-1:0] wdata;
    logic [DW-1:0] b0;
    logic [DW-1:0] b1;
    int            gap;
    int            stall_c;
    int            stall_w;
    int            calib_wait;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Handshake monitor on the falling edge: logs completed commands/beats and payload changes under stall
  cmd_t          cmd_q[$];
  logic [DW-1:0] wdf_q[$];
  int            ack_total = 0;
  int            hold_viol = 0;
  int            end_viol  = 0;
  logic          pend_c = 1'b0, pend_w = 1'b0;
  cmd_t          pend_cv;
  logic [DW-1:0] pend_wv;

  always @(negedge clk) begin
    if (rst) begin
      pend_c <= 1'b0;
      pend_w <= 1'b0;
    end else begin
      if (pend_c && (!app_en_o || {app_cmd_o, app_addr_o} != pend_cv)) hold_viol <= hold_viol + 1;
      if (pend_w && (!app_wdf_wren_o || app_wdf_data_o != pend_wv)) hold_viol <= hold_viol + 1;
      pend_c  <= app_en_o && !app_rdy_i;
      pend_cv <= {app_cmd_o, app_addr_o};
      pend_w  <= app_wdf_wren_o && !app_wdf_rdy_i;
      pend_wv <= app_wdf_data_o;
      if (app_en_o && app_rdy_i) cmd_q.push_back({app_cmd_o, app_addr_o});
      if (app_wdf_wren_o && app_wdf_rdy_i) wdf_q.push_back(app_wdf_data_o);
      if ((app_wdf_end_o !== app_wdf_wren_o) || (app_wdf_mask_o !== 16'h0)) end_viol <= end_viol + 1;
      if (ack_o) ack_total <= ack_total + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int c0, w0, ak0, hv0, ev0, t, first_t, ack_t, tc, td, rc, rw, gate_en, bstate;
    bit got_first, got_ack;
    logic [LW-1:0] dat;
    cmd_t exp0, exp1;
    c0 = cmd_q.size(); w0 = wdf_q.size(); ak0 = ack_total; hv0 = hold_viol; ev0 = end_viol;
    we_i = v.we; rd_i = v.rd; addr_i = v.addr; data_i = v.wdata;
    if (v.calib_wait > 0) begin
      calib_done_i = 1'b0;
      gate_en = 0;
      repeat (v.calib_wait) begin
        step();
        if (app_en_o || app_wdf_wren_o) gate_en++;
      end
      check($sformatf("v%0d calib_gate", idx), LW'(gate_en), LW'(0));
      calib_done_i = 1'b1;
    end
    t = 0; first_t = 0; ack_t = 0; tc = -1; td = -1; bstate = 0;
    rc = v.stall_c; rw = v.stall_w; got_first = 0; got_ack = 0; dat = '0;
    while (!got_ack && t < 200) begin
      app_rdy_i = 1'b1;
      app_wdf_rdy_i = 1'b1;
      if (app_en_o && cmd_q.size() == c0 && rc > 0) begin app_rdy_i = 1'b0; rc--; end
      if (app_wdf_wren_o && wdf_q.size() == w0 + 1 && rw > 0) begin app_wdf_rdy_i = 1'b0; rw--; end
      app_rd_data_valid_i = 1'b0;
      app_rd_data_end_i = 1'b0;
      if (!v.we && bstate == 0 && cmd_q.size() == c0 + 2) begin
        app_rd_data_valid_i = 1'b1; app_rd_data_end_i = 1'b1; app_rd_data_i = v.b0;
        tc = t; bstate = 1;
      end else if (!v.we && bstate == 1 && t == tc + v.gap) begin
        app_rd_data_valid_i = 1'b1; app_rd_data_end_i = 1'b1; app_rd_data_i = v.b1;
        td = t; bstate = 2;
      end
      step();
      t++;
      if (!got_first && (app_en_o || app_wdf_wren_o)) begin got_first = 1; first_t = t; end
      if (ack_o) begin got_ack = 1; ack_t = t; dat = data_o; end
    end
    app_rd_data_valid_i = 1'b0;
    app_rd_data_end_i = 1'b0;
    app_rdy_i = 1'b1;
    app_wdf_rdy_i = 1'b1;
    check($sformatf("v%0d ack_seen", idx), LW'(got_ack), LW'(1));
    if (v.we)
      check($sformatf("v%0d wr_latency", idx), LW'(ack_t - first_t), LW'(4 + v.stall_c + v.stall_w));
    else begin
      check($sformatf("v%0d rd_latency", idx), LW'(ack_t), LW'(td + 1));
      check($sformatf("v%0d rd_data", idx), dat, {v.b1, v.b0});
    end
    // Request stays up through ACK and HOLD, then the cache drops it
    step();
    step();
    we_i = 1'b0; rd_i = 1'b0;
    repeat (3) step();
    exp0 = {(v.we ? 3'b000 : 3'b001), v.a0};
    exp1 = {(v.we ? 3'b000 : 3'b001), v.a1};
    check($sformatf("v%0d cmd_count", idx), LW'(cmd_q.size() - c0), LW'(2));
    if (cmd_q.size() >= c0 + 2) begin
      check($sformatf("v%0d cmd0", idx), LW'(cmd_q[c0]), LW'(exp0));
      check($sformatf("v%0d cmd1", idx), LW'(cmd_q[c0 + 1]), LW'(exp1));
    end
    check($sformatf("v%0d wdf_count", idx), LW'(wdf_q.size() - w0), LW'(v.we ? 2 : 0));
    if (v.we && wdf_q.size() >= w0 + 2) begin
      check($sformatf("v%0d wdf0", idx), LW'(wdf_q[w0]), LW'(v.wdata[DW-1:0]));
      check($sformatf("v%0d wdf1", idx), LW'(wdf_q[w0 + 1]), LW'(v.wdata[LW-1:DW]));
    end
    check($sformatf("v%0d ack_count", idx), LW'(ack_total - ak0), LW'(1));
    check($sformatf("v%0d payload_stable", idx), LW'(hold_viol - hv0), LW'(0));
    check($sformatf("v%0d wdf_end_mask", idx), LW'(end_viol - ev0), LW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    vec_t vf;
    int c0, ak0, n;
    vt[0] = '{1'b1, 1'b0, 32'h0000_0040, {{32{4'hB}}, {32{4'hA}}}, '0, '0, 0, 0, 0, 0, 28'h000_0020, 28'h000_0028};
    vt[1] = '{1'b0, 1'b1, 32'h0000_0040, '0, {32{4'hC}}, {32{4'hD}}, 3, 0, 0, 0, 28'h000_0020, 28'h000_0028};
    vt[2] = '{1'b1, 1'b0, 32'h1234_5660,
              {128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978, 128'h0123_4567_89AB_CDEF_1122_3344_5566_7788},
              '0, '0, 0, 4, 3, 0, 28'h91A_2B30, 28'h91A_2B38};
    vt[3] = '{1'b0, 1'b1, 32'hFFFF_FFE0, '0, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555,
              128'h6666_7777_8888_9999_AAAA_BBBB_CAFE_F00D, 1, 0, 0, 10, 28'hFFF_FFF0, 28'hFFF_FFF8};
    vt[4] = '{1'b1, 1'b1, 32'h0000_0100, {{32{4'h9}}, {32{4'h3}}}, '0, '0, 0, 0, 0, 0, 28'h000_0080, 28'h000_0088};
    vt[5] = '{1'b0, 1'b1, 32'h0000_001F, '0, {32{4'h1}}, {32{4'h2}}, 2, 0, 0, 0, 28'h000_0000, 28'h000_0008};
    vf    = '{1'b0, 1'b1, 32'h0000_0060, '0, {32{4'hF}}, {32{4'h5}}, 3, 0, 0, 0, 28'h000_0030, 28'h000_0038};

    rst = 1'b1; we_i = 1'b0; rd_i = 1'b0; addr_i = '0; data_i = '0; calib_done_i = 1'b1;
    app_rdy_i = 1'b1; app_wdf_rdy_i = 1'b1; app_rd_data_i = '0;
    app_rd_data_valid_i = 1'b0; app_rd_data_end_i = 1'b0;
    repeat (3) step();
    check("reset ack_o", LW'(ack_o), LW'(0));
    check("reset app_en_o", LW'(app_en_o), LW'(0));
    check("reset app_wdf_wren_o", LW'(app_wdf_wren_o), LW'(0));
    check("reset app_cmd_o", LW'(app_cmd_o), LW'(0));
    check("reset app_addr_o", LW'(app_addr_o), LW'(0));
    check("reset data_o", data_o, LW'(0));
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) run_vec(vt[i], i);

    // Reset lands in RWAIT after the first beat; a late beat must then be ignored
    c0 = cmd_q.size();
    addr_i = 32'h0000_0080; rd_i = 1'b1;
    n = 0;
    while (cmd_q.size() < c0 + 2 && n < 50) begin step(); n++; end
    check("rst_seq cmds_issued", LW'(cmd_q.size() - c0), LW'(2));
    app_rd_data_valid_i = 1'b1; app_rd_data_i = {32{4'h7}};
    step();
    app_rd_data_valid_i = 1'b0;
    rst = 1'b1; rd_i = 1'b0;
    step();
    check("rst_seq ack_o", LW'(ack_o), LW'(0));
    check("rst_seq app_en_o", LW'(app_en_o), LW'(0));
    check("rst_seq app_wdf_wren_o", LW'(app_wdf_wren_o), LW'(0));
    check("rst_seq app_cmd_o", LW'(app_cmd_o), LW'(0));
    check("rst_seq app_addr_o", LW'(app_addr_o), LW'(0));
    check("rst_seq data_o", data_o, LW'(0));
    rst = 1'b0;
    ak0 = ack_total;
    c0 = cmd_q.size();
    app_rd_data_valid_i = 1'b1; app_rd_data_i = {32{4'h6}};
    step();
    app_rd_data_valid_i = 1'b0;
    repeat (3) step();
    check("late_beat ack_count", LW'(ack_total - ak0), LW'(0));
    check("late_beat cmd_count", LW'(cmd_q.size() - c0), LW'(0));
    check("late_beat data_o", data_o, LW'(0));
    run_vec(vf, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
